leitor_rom: RTL and testbench

Sequential ROM reader that sits directly upstream of the 512×8 `ROM` block. It drives `Endereco` and consumes the registered `Dados` that the ROM returns one clock later. On a start command it streams a programmed number of consecutive bytes to the downstream consumer over a valid/ready handshake. It absorbs the ROM's one-cycle read latency and downstream back-pressure with a 3-entry FIFO.

---
 rtl/leitor_rom.sv | 136 +++++++++++++
 tb/tb_leitor_rom.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_rom.sv
// Sequential reader for the 512x8 ROM. Issues consecutive addresses from EndInicial,
// absorbs the ROM's one-cycle latency and downstream back-pressure in a 3-entry FIFO,
// and streams the bytes out over a Valido/Pronto handshake.
module leitor_rom (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       Iniciar,
  input  logic [8:0] EndInicial,
  input  logic [9:0] Quantidade,
  output logic [8:0] Endereco,
  input  logic [7:0] Dados,
  output logic [7:0] Saida,
  output logic       Valido,
  input  logic       Pronto,
  output logic       Ocupado,
  output logic       Concluido
);

  typedef enum logic [1:0] {StOcioso, StLendo, StEsvaziando} estado_e;

  estado_e     estado_q, estado_d;
  logic [8:0]  endereco_q, endereco_d;
  logic [9:0]  restante_q, restante_d;  // requests still to issue after the current one
  logic        r_q, r_d;                // Endereco holds a real request this cycle
  logic        p_q, p_d;                // Dados holds a requested byte this cycle
  logic        ocupado_q, ocupado_d;
  logic        concluido_q, concluido_d;
  logic [7:0]  fifo_q [3];
  logic [7:0]  fifo_d [3];
  logic [1:0]  cnt_q, cnt_d;

  logic [9:0]  qtd_limitada;
  logic        pop;
  logic [2:0]  ocupacao;
  logic        pode_emitir;
  logic        drenado;
  logic [1:0]  idx_escrita;

  assign Endereco  = endereco_q;
  assign Saida     = fifo_q[0];
  assign Valido    = (cnt_q != 2'd0);
  assign Ocupado   = ocupado_q;
  assign Concluido = concluido_q;

  assign qtd_limitada = (Quantidade > 10'd512) ? 10'd512 : Quantidade;
  assign pop          = Valido && Pronto;
  // Bytes already owned by the pipeline: buffered, returning from ROM, and requested.
  assign ocupacao     = {1'b0, cnt_q} + {2'b00, p_q} + {2'b00, r_q};
  // Issue only if the new request still fits after this edge's pop.
  assign pode_emitir  = ocupacao < (3'd3 + {2'b00, pop});
  // Everything is out of the pipeline once this edge's pop completes.
  assign drenado      = !r_q && !p_q && (cnt_q == {1'b0, pop});

  // Shift-register FIFO: head is always entry 0, so Saida holds still while stalled.
  always_comb begin
    fifo_d      = fifo_q;
    idx_escrita = cnt_q - {1'b0, pop};
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      fifo_d[1] = fifo_q[2];
    end
    if (p_q) begin
      fifo_d[idx_escrita] = Dados;
    end
    cnt_d = cnt_q - {1'b0, pop} + {1'b0, p_q};
  end

  // Control FSM: address issue, request flags and completion signalling.
  always_comb begin
    estado_d    = estado_q;
    endereco_d  = endereco_q;
    restante_d  = restante_q;
    r_d         = 1'b0;
    p_d         = r_q;
    ocupado_d   = ocupado_q;
    concluido_d = 1'b0;
    unique case (estado_q)
      StOcioso: begin
        if (Iniciar) begin
          if (qtd_limitada != 10'd0) begin
            endereco_d = EndInicial;
            r_d        = 1'b1;
            restante_d = qtd_limitada - 10'd1;
            ocupado_d  = 1'b1;
            estado_d   = StLendo;
          end else begin
            concluido_d = 1'b1;
          end
        end
      end
      StLendo: begin
        if (restante_q == 10'd0) begin
          estado_d = StEsvaziando;
        end else if (pode_emitir) begin
          endereco_d = endereco_q + 9'd1;
          r_d        = 1'b1;
          restante_d = restante_q - 10'd1;
        end
      end
      StEsvaziando: begin
        if (drenado) begin
          concluido_d = 1'b1;
          ocupado_d   = 1'b0;
          estado_d    = StOcioso;
        end
      end
      default: estado_d = StOcioso;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q    <= StOcioso;
      endereco_q  <= 9'd0;
      restante_q  <= 10'd0;
      r_q         <= 1'b0;
      p_q         <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      fifo_q      <= '{default: 8'h00};
      cnt_q       <= 2'd0;
    end else begin
      estado_q    <= estado_d;
      endereco_q  <= endereco_d;
      restante_q  <= restante_d;
      r_q         <= r_d;
      p_q         <= p_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
      fifo_q      <= fifo_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_leitor_rom.sv
// Directed bench for leitor_rom with a behavioural registered ROM model.
module tb_leitor_rom;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b1;
  logic       Iniciar = 1'b0;
  logic [8:0] EndInicial = '0;
  logic [9:0] Quantidade = '0;
  logic [8:0] Endereco;
  logic [7:0] Dados;
  logic [7:0] Saida;
  logic       Valido;
  logic       Pronto = 1'b0;
  logic       Ocupado;
  logic       Concluido;

  int checks = 0;
  int failures = 0;

  leitor_rom dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .Iniciar   (Iniciar),
    .EndInicial(EndInicial),
    .Quantidade(Quantidade),
    .Endereco  (Endereco),
    .Dados     (Dados),
    .Saida     (Saida),
    .Valido    (Valido),
    .Pronto    (Pronto),
    .Ocupado   (Ocupado),
    .Concluido (Concluido)
  );

  always #5 CLK = ~CLK;

  // ROM contents: fixed bytes where the test plan names them, a formula elsewhere.
  function automatic logic [7:0] rom_val(input logic [8:0] a);
    case (a)
      9'd0:   return 8'd2;
      9'd1:   return 8'd6;
      9'd2:   return 8'd7;
      9'd3:   return 8'd2;
      9'd4:   return 8'd2;
      9'd5:   return 8'd0;
      9'd6:   return 8'd255;
      9'd7:   return 8'd3;
      9'd8:   return 8'd255;
      9'd9:   return 8'd1;
      9'd510: return 8'd255;
      9'd511: return 8'd255;
      default: return 8'((int'(a) * 37 + 11) % 256);
    endcase
  endfunction

  // Registered ROM: Dados holds the word addressed in the previous cycle.
  always @(posedge CLK) Dados <= rom_val(Endereco);

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drives Iniciar so the next edge is edge 0; returns in cycle 1.
  task automatic start(input logic [8:0] a, input logic [9:0] q);
    EndInicial = a;
    Quantidade = q;
    Iniciar    = 1'b1;
    step();
    Iniciar = 1'b0;
  endtask

  task automatic test_reset();
    #1 Reset_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      Iniciar    = 1'($urandom);
      EndInicial = 9'($urandom);
      Quantidade = 10'($urandom);
      Pronto     = 1'($urandom);
      checks++;
      if ({Endereco, Saida, Valido, Ocupado, Concluido} !== 20'd0) begin
        failures++;
        $display("FAIL reset_outputs c=%0d got=%h exp=0", c,
                 {Endereco, Saida, Valido, Ocupado, Concluido});
      end
      step();
    end
    Iniciar = 1'b0;
    Pronto  = 1'b0;
    Reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (Valido !== 1'b0 || Concluido !== 1'b0 || Ocupado !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle c=%0d got=%b%b%b exp=000", c, Valido, Concluido, Ocupado);
      end
    end
  endtask

  task automatic test_basic();
    Pronto = 1'b1;
    start(9'd0, 10'd10);
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if (Valido !== (c >= 3 && c <= 12)) begin
        failures++;
        $display("FAIL basic_valido c=%0d got=%b exp=%b", c, Valido, (c >= 3 && c <= 12));
      end
      if (c >= 3 && c <= 12) begin
        checks++;
        if (Saida !== rom_val(9'(c - 3))) begin
          failures++;
          $display("FAIL basic_saida c=%0d got=%0d exp=%0d", c, Saida, rom_val(9'(c - 3)));
        end
      end
      checks++;
      if (Ocupado !== (c <= 12) || Concluido !== (c == 13)) begin
        failures++;
        $display("FAIL basic_ctrl c=%0d got ocup=%b conc=%b exp ocup=%b conc=%b",
                 c, Ocupado, Concluido, (c <= 12), (c == 13));
      end
      if (c == 1) begin
        checks++;
        if (Endereco !== 9'd0) begin
          failures++;
          $display("FAIL basic_endereco got=%0d exp=0", Endereco);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    Pronto = 1'b1;
    start(9'd0, 10'd2);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (Valido !== (c == 3 || c == 4) || Concluido !== (c == 5) || Ocupado !== (c <= 4)) begin
        failures++;
        $display("FAIL b2b_first_ctrl c=%0d got v=%b c=%b o=%b", c, Valido, Concluido, Ocupado);
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (Saida !== rom_val(9'(c - 3))) begin
          failures++;
          $display("FAIL b2b_first_saida c=%0d got=%0d exp=%0d", c, Saida, rom_val(9'(c - 3)));
        end
      end
      if (c == 5) begin
        EndInicial = 9'd8;
        Quantidade = 10'd2;
        Iniciar    = 1'b1;
      end
      step();
      Iniciar = 1'b0;
    end
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (Valido !== (c == 3 || c == 4) || Concluido !== (c == 5) || Ocupado !== (c <= 4)) begin
        failures++;
        $display("FAIL b2b_second_ctrl c=%0d got v=%b c=%b o=%b", c, Valido, Concluido, Ocupado);
      end
      if (c == 1) begin
        checks++;
        if (Endereco !== 9'd8) begin
          failures++;
          $display("FAIL b2b_second_endereco got=%0d exp=8", Endereco);
        end
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (Saida !== rom_val(9'(c + 5))) begin
          failures++;
          $display("FAIL b2b_second_saida c=%0d got=%0d exp=%0d", c, Saida, rom_val(9'(c + 5)));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int         idx = 0;
    bit         done = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_saida = '0;
    Pronto = 1'b1;
    start(9'd0, 10'd10);
    for (int c = 1; c <= 60 && !done; c++) begin
      Pronto = (c >= 4 && c <= 9) ? 1'b0 : ((c < 4) ? 1'b1 : (c % 2 == 0));
      if (prev_stall) begin
        checks++;
        if (Valido !== 1'b1 || Saida !== prev_saida) begin
          failures++;
          $display("FAIL bp_stable c=%0d got v=%b s=%0d exp v=1 s=%0d", c, Valido, Saida, prev_saida);
        end
      end
      if (Concluido === 1'b1) begin
        checks++;
        if (idx != 10) begin
          failures++;
          $display("FAIL bp_count got=%0d exp=10", idx);
        end
        done = 1;
      end else if (Valido === 1'b1 && Pronto) begin
        checks++;
        if (idx >= 10 || Saida !== rom_val(9'(idx))) begin
          failures++;
          $display("FAIL bp_saida idx=%0d got=%0d exp=%0d", idx, Saida, rom_val(9'(idx)));
        end
        idx++;
      end
      prev_stall = (Valido === 1'b1) && !Pronto;
      prev_saida = Saida;
      step();
    end
    Pronto = 1'b1;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL bp_timeout got=no_concluido exp=concluido");
    end
  endtask

  task automatic test_wrap();
    logic [8:0] exp_end [4];
    logic [7:0] exp_sai [4];
    exp_end = '{9'd510, 9'd511, 9'd0, 9'd1};
    exp_sai = '{8'd255, 8'd255, 8'd2, 8'd6};
    Pronto = 1'b1;
    start(9'd510, 10'd4);
    for (int c = 1; c <= 8; c++) begin
      if (c <= 4) begin
        checks++;
        if (Endereco !== exp_end[c-1]) begin
          failures++;
          $display("FAIL wrap_endereco c=%0d got=%0d exp=%0d", c, Endereco, exp_end[c-1]);
        end
      end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (Valido !== 1'b1 || Saida !== exp_sai[c-3]) begin
          failures++;
          $display("FAIL wrap_saida c=%0d got v=%b s=%0d exp=%0d", c, Valido, Saida, exp_sai[c-3]);
        end
      end
      checks++;
      if (Concluido !== (c == 7)) begin
        failures++;
        $display("FAIL wrap_concluido c=%0d got=%b exp=%b", c, Concluido, (c == 7));
      end
      step();
    end
  endtask

  // Runs right after the wrap test, which leaves Endereco at 1.
  task automatic test_zero();
    start(9'd5, 10'd0);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (Concluido !== (c == 1) || Valido !== 1'b0 || Ocupado !== 1'b0 || Endereco !== 9'd1) begin
        failures++;
        $display("FAIL zero_qtd c=%0d got c=%b v=%b o=%b e=%0d exp c=%b v=0 o=0 e=1",
                 c, Concluido, Valido, Ocupado, Endereco, (c == 1));
      end
      step();
    end
  endtask

  // 600 clamps to 512; a mid-run Iniciar must be ignored.
  task automatic test_full();
    int  n = 0;
    int  conc_c = -1;
    Pronto = 1'b1;
    start(9'd100, 10'd600);
    for (int c = 1; c <= 700 && conc_c < 0; c++) begin
      if (c == 50) begin
        EndInicial = 9'd300;
        Quantidade = 10'd3;
        Iniciar    = 1'b1;
      end
      if (Valido === 1'b1) begin
        checks++;
        if (Saida !== rom_val(9'((100 + n) % 512))) begin
          failures++;
          $display("FAIL full_saida n=%0d got=%0d exp=%0d", n, Saida, rom_val(9'((100 + n) % 512)));
        end
        n++;
      end
      if (Concluido === 1'b1) conc_c = c;
      step();
      Iniciar = 1'b0;
    end
    checks++;
    if (n != 512 || conc_c != 515) begin
      failures++;
      $display("FAIL full_count got n=%0d conc=%0d exp n=512 conc=515", n, conc_c);
    end
  endtask

  task automatic test_reset_mid();
    Pronto = 1'b1;
    start(9'd20, 10'd10);
    for (int c = 1; c <= 6; c++) step();
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({Endereco, Saida, Valido, Ocupado, Concluido} !== 20'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=0", {Endereco, Saida, Valido, Ocupado, Concluido});
    end
    step();
    step();
    Reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (Concluido !== 1'b0 || Valido !== 1'b0 || Ocupado !== 1'b0) begin
        failures++;
        $display("FAIL midreset_idle c=%0d got c=%b v=%b o=%b exp 000", c, Concluido, Valido, Ocupado);
      end
    end
    start(9'd3, 10'd5);
    for (int c = 1; c <= 9; c++) begin
      if (c == 1) begin
        checks++;
        if (Endereco !== 9'd3) begin
          failures++;
          $display("FAIL restart_endereco got=%0d exp=3", Endereco);
        end
      end
      checks++;
      if (Valido !== (c >= 3 && c <= 7) || Concluido !== (c == 8) || Ocupado !== (c <= 7)) begin
        failures++;
        $display("FAIL restart_ctrl c=%0d got v=%b c=%b o=%b", c, Valido, Concluido, Ocupado);
      end
      if (c >= 3 && c <= 7) begin
        checks++;
        if (Saida !== rom_val(9'(c))) begin
          failures++;
          $display("FAIL restart_saida c=%0d got=%0d exp=%0d", c, Saida, rom_val(9'(c)));
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_zero();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
